// File: rtl/two_bit_tdm_demux_pkg.sv
// Shared definitions for the two-bit TDM demultiplexer: state encoding,
// symbol/frame geometry and the error counter ceiling.
package two_bit_tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int SLOT_W    = 2;
    localparam int NUM_SLOTS = 4;

    localparam logic [3:0] ERR_MAX = 4'hF;

endpackage

// File: rtl/two_bit_slot_reg.sv
// Two-bit storage element with load enable and asynchronous reset. Used for
// the shadow slots and for the visible frame outputs.
module two_bit_slot_reg
    import two_bit_tdm_demux_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [SLOT_W-1:0] d,
    output logic [SLOT_W-1:0] q
);

    // Capture d whenever enabled; clear on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/two_bit_tdm_demux.sv
// Four-slot TDM demultiplexer for a serial 2-bit symbol stream. Symbols are
// collected into shadow slots while a frame is in progress; the visible
// outputs u..x are loaded all at once when slot 3 arrives, so a partial frame
// is never observable. Alignment is tracked with a HUNT/LOCKED state machine.
module two_bit_tdm_demux
    import two_bit_tdm_demux_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              sync,
    input  logic [SLOT_W-1:0] d,
    output logic [SLOT_W-1:0] u,
    output logic [SLOT_W-1:0] v,
    output logic [SLOT_W-1:0] w,
    output logic [SLOT_W-1:0] x,
    output logic [1:0]        s,
    output logic              locked,
    output logic              frame_valid,
    output logic              sync_err,
    output logic [3:0]        err_count
);

    state_t            state;
    state_t            next_state;
    logic [1:0]        next_s;
    logic [2:0]        shadow_en;
    logic              out_en;
    logic              set_fv;
    logic              set_se;
    logic [SLOT_W-1:0] shadow0;
    logic [SLOT_W-1:0] shadow1;
    logic [SLOT_W-1:0] shadow2;

    // Decode the accepted symbol into register enables and the next state/slot.
    always_comb begin
        next_state = state;
        next_s     = s;
        shadow_en  = 3'b000;
        out_en     = 1'b0;
        set_fv     = 1'b0;
        set_se     = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        shadow_en[0] = 1'b1;
                        next_s       = 2'd1;
                        next_state   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync always restarts the frame; it is only an error
                        // when it cuts a frame short.
                        shadow_en[0] = 1'b1;
                        next_s       = 2'd1;
                        set_se       = (s != 2'd0);
                    end else if (s == 2'd0) begin
                        set_se     = 1'b1;
                        next_s     = 2'd0;
                        next_state = HUNT;
                    end else if (s == 2'd3) begin
                        out_en = 1'b1;
                        set_fv = 1'b1;
                        next_s = 2'd0;
                    end else begin
                        shadow_en[1] = (s == 2'd1);
                        shadow_en[2] = (s == 2'd2);
                        next_s       = s + 2'd1;
                    end
                end
                default: begin
                    next_state = HUNT;
                    next_s     = 2'd0;
                end
            endcase
        end
    end

    // Control state, slot index, status pulses and the saturating error count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            s           <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 4'd0;
        end else begin
            state       <= next_state;
            s           <= next_s;
            frame_valid <= set_fv;
            sync_err    <= set_se;
            if (set_se && (err_count != ERR_MAX)) begin
                err_count <= err_count + 4'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

    two_bit_slot_reg shadow_slot0 (
        .clock (clock),
        .reset (reset),
        .en    (shadow_en[0]),
        .d     (d),
        .q     (shadow0)
    );

    two_bit_slot_reg shadow_slot1 (
        .clock (clock),
        .reset (reset),
        .en    (shadow_en[1]),
        .d     (d),
        .q     (shadow1)
    );

    two_bit_slot_reg shadow_slot2 (
        .clock (clock),
        .reset (reset),
        .en    (shadow_en[2]),
        .d     (d),
        .q     (shadow2)
    );

    two_bit_slot_reg out_u (
        .clock (clock),
        .reset (reset),
        .en    (out_en),
        .d     (shadow0),
        .q     (u)
    );

    two_bit_slot_reg out_v (
        .clock (clock),
        .reset (reset),
        .en    (out_en),
        .d     (shadow1),
        .q     (v)
    );

    two_bit_slot_reg out_w (
        .clock (clock),
        .reset (reset),
        .en    (out_en),
        .d     (shadow2),
        .q     (w)
    );

    // Slot 3 goes straight to x so the frame appears one edge after it arrives.
    two_bit_slot_reg out_x (
        .clock (clock),
        .reset (reset),
        .en    (out_en),
        .d     (d),
        .q     (x)
    );

endmodule

// File: tb/tb_two_bit_tdm_demux.sv
// Scoreboard bench for the two-bit TDM demultiplexer: every accepted symbol
// pushes the expected post-edge view into a queue that a negedge monitor
// drains, alongside directed scenarios and a randomized stream.
module tb_two_bit_tdm_demux;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       sync;
    logic [1:0] d;
    logic [1:0] u, v, w, x, s;
    logic       locked, frame_valid, sync_err;
    logic [3:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       fv;
        logic       se;
        logic       lk;
        logic [1:0] s;
        logic [1:0] u, v, w, x;
        logic [3:0] ec;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the partial frame as a list of symbols
    bit         m_hunt;
    logic [1:0] m_frame[$];
    logic [1:0] m_vis[4];
    int         m_err;

    two_bit_tdm_demux dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .sync        (sync),
        .d           (d),
        .u           (u),
        .v           (v),
        .w           (w),
        .x           (x),
        .s           (s),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .err_count   (err_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_hunt = 1'b1;
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_vis[i] = 2'b00;
        m_err = 0;
    endtask

    // Drive one symbol, and after the accepting edge record what should follow
    task automatic applyStimulus(input logic sy, input logic [1:0] dd);
        exp_t e;
        @(negedge clock);
        in_valid = 1'b1;
        sync     = sy;
        d        = dd;
        @(posedge clock);
        e.fv = 1'b0;
        e.se = 1'b0;
        if (m_hunt) begin
            if (sy) begin
                m_frame.delete();
                m_frame.push_back(dd);
                m_hunt = 1'b0;
            end
        end else if (sy) begin
            if (m_frame.size() != 0) begin
                e.se = 1'b1;
                if (m_err < 15) m_err++;
            end
            m_frame.delete();
            m_frame.push_back(dd);
        end else if (m_frame.size() == 0) begin
            e.se = 1'b1;
            if (m_err < 15) m_err++;
            m_hunt = 1'b1;
        end else begin
            m_frame.push_back(dd);
            if (m_frame.size() == 4) begin
                for (int i = 0; i < 4; i++) m_vis[i] = m_frame[i];
                e.fv = 1'b1;
                m_frame.delete();
            end
        end
        e.s  = 2'(m_frame.size());
        e.lk = !m_hunt;
        e.u  = m_vis[0];
        e.v  = m_vis[1];
        e.w  = m_vis[2];
        e.x  = m_vis[3];
        e.ec = 4'(m_err);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
        d        = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_u"}, 8'(u), 8'h0);
        checkOutput({tag, "_v"}, 8'(v), 8'h0);
        checkOutput({tag, "_w"}, 8'(w), 8'h0);
        checkOutput({tag, "_x"}, 8'(x), 8'h0);
        checkOutput({tag, "_s"}, 8'(s), 8'h0);
        checkOutput({tag, "_locked"}, 8'(locked), 8'h0);
        checkOutput({tag, "_frame_valid"}, 8'(frame_valid), 8'h0);
        checkOutput({tag, "_sync_err"}, 8'(sync_err), 8'h0);
        checkOutput({tag, "_err_count"}, 8'(err_count), 8'h0);
    endtask

    // Assert reset just after a negedge so the monitor has already drained
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        model_clear();
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compare against the queued expectation, otherwise expect quiet
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("mon_frame_valid", 8'(frame_valid), 8'(e.fv));
                    checkOutput("mon_sync_err", 8'(sync_err), 8'(e.se));
                    checkOutput("mon_locked", 8'(locked), 8'(e.lk));
                    checkOutput("mon_s", 8'(s), 8'(e.s));
                    checkOutput("mon_u", 8'(u), 8'(e.u));
                    checkOutput("mon_v", 8'(v), 8'(e.v));
                    checkOutput("mon_w", 8'(w), 8'(e.w));
                    checkOutput("mon_x", 8'(x), 8'(e.x));
                    checkOutput("mon_err_count", 8'(err_count), 8'(e.ec));
                end else begin
                    checkOutput("idle_frame_valid", 8'(frame_valid), 8'h0);
                    checkOutput("idle_sync_err", 8'(sync_err), 8'h0);
                    checkOutput("idle_u", 8'(u), 8'(m_vis[0]));
                    checkOutput("idle_x", 8'(x), 8'(m_vis[3]));
                    checkOutput("idle_s", 8'(s), 8'(m_frame.size()));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic sy;
        reset    = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        d        = 2'b00;
        model_clear();
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset0");
        idle(2);
        @(negedge clock);
        reset = 1'b0;

        // Aligned frame on consecutive cycles
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b0, 2'b10);
        applyStimulus(1'b0, 2'b11);
        applyStimulus(1'b0, 2'b00);
        settle();
        checkOutput("aligned_fv", 8'(frame_valid), 8'h1);
        checkOutput("aligned_u", 8'(u), 8'h1);
        checkOutput("aligned_v", 8'(v), 8'h2);
        checkOutput("aligned_w", 8'(w), 8'h3);
        checkOutput("aligned_x", 8'(x), 8'h0);
        checkOutput("aligned_s", 8'(s), 8'h0);

        // Missing sync after a complete frame
        applyStimulus(1'b0, 2'b11);
        settle();
        checkOutput("missing_se", 8'(sync_err), 8'h1);
        checkOutput("missing_locked", 8'(locked), 8'h0);
        checkOutput("missing_u_kept", 8'(u), 8'h1);
        checkOutput("missing_w_kept", 8'(w), 8'h3);
        applyStimulus(1'b0, 2'b10);
        applyStimulus(1'b0, 2'b01);
        settle();
        checkOutput("hunt_ignores_locked", 8'(locked), 8'h0);
        checkOutput("hunt_ignores_s", 8'(s), 8'h0);
        applyStimulus(1'b1, 2'b10);
        settle();
        checkOutput("relock_locked", 8'(locked), 8'h1);
        checkOutput("relock_s", 8'(s), 8'h1);

        // Same frame with gaps between symbols
        do_reset("reset_gap");
        applyStimulus(1'b1, 2'b01);
        idle(3);
        applyStimulus(1'b0, 2'b10);
        idle(3);
        applyStimulus(1'b0, 2'b11);
        idle(3);
        checkOutput("gap_u_hidden", 8'(u), 8'h0);
        checkOutput("gap_w_hidden", 8'(w), 8'h0);
        applyStimulus(1'b0, 2'b00);
        settle();
        checkOutput("gap_fv", 8'(frame_valid), 8'h1);
        checkOutput("gap_u", 8'(u), 8'h1);
        checkOutput("gap_v", 8'(v), 8'h2);
        checkOutput("gap_w", 8'(w), 8'h3);
        checkOutput("gap_x", 8'(x), 8'h0);

        // Early sync after slots 0 and 1
        do_reset("reset_early");
        applyStimulus(1'b1, 2'b00);
        applyStimulus(1'b0, 2'b01);
        applyStimulus(1'b1, 2'b10);
        settle();
        checkOutput("early_se", 8'(sync_err), 8'h1);
        checkOutput("early_fv", 8'(frame_valid), 8'h0);
        checkOutput("early_err_count", 8'(err_count), 8'h1);
        checkOutput("early_s", 8'(s), 8'h1);
        applyStimulus(1'b0, 2'b01);
        applyStimulus(1'b0, 2'b10);
        applyStimulus(1'b0, 2'b11);
        settle();
        checkOutput("early_done_fv", 8'(frame_valid), 8'h1);
        checkOutput("early_done_u", 8'(u), 8'h2);
        checkOutput("early_done_x", 8'(x), 8'h3);

        // Reset mid-frame after slot 2
        applyStimulus(1'b1, 2'b11);
        applyStimulus(1'b0, 2'b11);
        applyStimulus(1'b0, 2'b11);
        do_reset("reset_mid");
        applyStimulus(1'b0, 2'b01);
        applyStimulus(1'b0, 2'b10);
        applyStimulus(1'b0, 2'b11);
        applyStimulus(1'b0, 2'b01);
        settle();
        checkOutput("mid_locked", 8'(locked), 8'h0);
        checkOutput("mid_fv", 8'(frame_valid), 8'h0);
        checkOutput("mid_u", 8'(u), 8'h0);

        // Twenty early-sync violations saturate the counter
        do_reset("reset_sat");
        applyStimulus(1'b1, 2'b00);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'(i));
        settle();
        checkOutput("sat_err_count", 8'(err_count), 8'hF);

        // Randomized stream with gaps, biased towards mostly legal framing
        do_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            if (!m_hunt && m_frame.size() == 0)
                sy = ($urandom_range(0, 7) != 0);
            else
                sy = ($urandom_range(0, 5) == 0);
            applyStimulus(sy, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        checkOutput("queue_drained", 8'(exp_q.size()), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/two_bit_tdm_demux.md
TWO_BIT_TDM_DEMUX -- requirements
Module: two_bit_tdm_demux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be exactly as follows, with clock and reset listed first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  d/sync carry a symbol this cycle
- sync  in  1  marks the symbol as slot 0 of a frame
- d  in  2  serial 2-bit symbol
- u  out  2  slot-0 symbol of the last complete frame
- v  out  2  slot-1 symbol of the last complete frame
- w  out  2  slot-2 symbol of the last complete frame
- x  out  2  slot-3 symbol of the last complete frame
- s  out  2  slot index the next accepted symbol will occupy
- locked  out  1  frame alignment held
- frame_valid  out  1  one-cycle pulse: u..x just updated
- sync_err  out  1  one-cycle pulse: alignment violation
- err_count  out  4  saturating count of sync_err pulses

Function
REQ-003 States SHALL be HUNT and LOCKED; locked=1 if and only if state=LOCKED.
REQ-004 HUNT behaviour:
- in_valid=1 with sync=0: discard the symbol; stay in HUNT; s stays 0.
- in_valid=1 with sync=1: write d to shadow slot 0; set s=1; go to LOCKED.
REQ-005 LOCKED, in_valid=1, sync=0, s in {1,2}: write d to shadow[s]; s increments.
REQ-006 LOCKED, in_valid=1, sync=0, s=3 (frame completion), at the same edge:
- u,v,w load shadow slots 0,1,2;
- x loads d directly;
- s wraps to 0;
- frame_valid is asserted for exactly the following cycle.
REQ-007 LOCKED, in_valid=1, sync=1, s=0: treated as a normal slot-0 write; s becomes 1.
REQ-008 LOCKED, in_valid=1, sync=1, s not 0 (early sync):
- pulse sync_err;
- discard the partial frame;
- write d to shadow slot 0; set s=1; stay in LOCKED.
REQ-009 LOCKED, in_valid=1, sync=0, s=0 (missing sync):
- pulse sync_err;
- discard the symbol;
- go to HUNT with s=0.
REQ-010 in_valid=0 SHALL hold the state, s, and the shadow registers; gaps between symbols are legal in any slot.
REQ-011 u, v, w and x SHALL change only on frame completion; partial frames SHALL never be visible on them.
REQ-012 err_count SHALL increment on each sync_err pulse and saturate at 15 (4'hF).
REQ-013 frame_valid and sync_err SHALL be registered outputs and SHALL never both be asserted in the same cycle.
REQ-014 Latency SHALL be one edge: from the accepting edge of the slot-3 symbol to the updated u..x with frame_valid=1.

Reset
REQ-015 While reset=1, the block SHALL immediately hold the following values:
- state=HUNT
- s=0
- u=v=w=x=2'b00
- shadow registers all 0
- frame_valid=0, sync_err=0, err_count=0, locked=0
REQ-016 Reset asserted mid-frame SHALL discard the partial frame; the first symbol accepted after release SHALL be processed as in HUNT.

Structure
REQ-017 A shared package SHALL hold:
- the state encoding (HUNT=0, LOCKED=1);
- SLOT_W=2 and NUM_SLOTS=4;
- ERR_MAX=15.
REQ-018 One sub-module, two_bit_slot_reg, SHALL be used: a 2-bit register with enable and async reset. It SHALL be instantiated for the shadow slots 0..2 and for u, v, w and x.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Aligned frame: reset; then symbols (sync=1,d=01),(0,10),(0,11),(0,00) on consecutive cycles -> next cycle frame_valid=1, u=01, v=10, w=11, x=00, s=0.
- Gaps: the same frame with in_valid=0 for 3 cycles between each symbol -> identical result; u..x unchanged until the 4th symbol.
- Early sync: after slots 0,1 are accepted, a symbol with sync=1, d=10 -> sync_err pulse, err_count=1, s=1; the next 3 symbols complete a frame with u=10.
- Missing sync: after a complete frame, a symbol with sync=0 -> sync_err, locked=0, u..x retain the previous frame; non-sync symbols are then ignored until sync=1.
- Saturation: 20 consecutive early-sync violations -> err_count=15, never wraps.
- Reset mid-frame: assert reset after slot 2 -> all outputs 0 immediately; after release, symbols without sync are ignored (HUNT).
